bcd_to_bin_seq: RTL

- Sequential BCD-to-binary converter using reverse double-dabble: shift right one bit per clock, subtract 3 from any BCD digit >= 8.
- Inverse of the clock system's binary-to-BCD place-value splitter. Takes four BCD digits (thousands, hundreds, tens, ones), e.g. a value set on the display, and returns a 14-bit binary count for the time/counter logic.
- Uses a start/busy/done handshake so a conversion costs one small datapath over BIN_W clocks instead of a wide combinational chain.

---
 rtl/bcd_to_bin_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bcd_to_bin_seq.sv
// Four-digit BCD to 14-bit binary converter using reverse double-dabble:
// one right shift plus per-digit "subtract 3 if >= 8" correction per clock.
module bcd_to_bin_seq #(
  parameter int BIN_W = 14,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       tho,
  input  logic [3:0]       hun,
  input  logic [3:0]       ten,
  input  logic [3:0]       one,
  output logic [BIN_W-1:0] bin_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Handshake: start is sampled on every rising edge where busy=0; a request
  // is accepted there. busy stays high for the whole conversion and any start
  // seen while busy=1 is dropped. done pulses for one cycle when bin_out/err
  // take their new value; both then hold until the next accepted request.

  localparam int SR_W = 16 + BIN_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               bad_digit;
  logic [SR_W-1:0]    shifted;
  logic [SR_W-1:0]    corrected;

  always_comb begin
    bad_digit = (tho > 4'd9) || (hun > 4'd9) || (ten > 4'd9) || (one > 4'd9);
    shifted   = sr_q >> 1;
    corrected = shifted;
    // Each BCD digit above the binary field is corrected independently.
    for (int i = 0; i < 4; i++) begin
      if (shifted[BIN_W + 4*i +: 4] >= 4'd8) begin
        corrected[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad_digit) begin
            bin_d  = '0;
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            sr_d    = {tho, hun, ten, one, {BIN_W{1'b0}}};
            cnt_d   = '0;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        sr_d  = corrected;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bin_d   = corrected[BIN_W-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
